// File: rtl/product_select_ctrl_pkg.sv
// Shared constants and move-FSM encoding for the product selection front end.
// The VGA pixel controller imports the same package, so the encodings must stay fixed.
package product_select_ctrl_pkg;
    localparam int NUM_OF_PRDCT = 12;
    localparam int CURSOR_W     = 4;
    localparam int NUM_BTN      = 4;

    localparam int BTN_NEXT_IDX   = 0;
    localparam int BTN_PREV_IDX   = 1;
    localparam int BTN_TOGGLE_IDX = 2;
    localparam int BTN_CLEAR_IDX  = 3;

    typedef enum logic [1:0] {
        MV_IDLE   = 2'd0,
        MV_HOLD   = 2'd1,
        MV_REPEAT = 2'd2
    } move_state_e;
endpackage

// File: rtl/btn_edge_detect.sv
// Registers a vector of pre-debounced button levels and flags rising edges.
module btn_edge_detect #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] btn,
    output logic [W-1:0] rise
);
    logic [W-1:0] btn_q_r;

    // Previous-cycle sample of every button
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_q_r <= {W{1'b0}};
        end else begin
            btn_q_r <= btn;
        end
    end

    assign rise = btn & ~btn_q_r;
endmodule

// File: rtl/product_select_ctrl.sv
// Front-panel button handler producing the highlighted product list for the VGA side.
// Internal state updates on the press edge; output registers follow one cycle later.
module product_select_ctrl #(
    parameter int NUM_OF_PRDCT   = 12,
    parameter int CURSOR_W       = 4,
    parameter int HOLD_CYCLES    = 25_000_000,
    parameter int REPEAT_CYCLES  = 10_000_000,
    parameter int TMR_W          = 25,
    parameter int CURSOR_IN_LIST = 1
) (
    input  logic                    CLOCK_50,
    input  logic                    RESET_N,
    input  logic                    BTN_NEXT,
    input  logic                    BTN_PREV,
    input  logic                    BTN_TOGGLE,
    input  logic                    BTN_CLEAR,
    input  logic                    LOCK,
    output logic [NUM_OF_PRDCT-1:0] HighlightedProductList,
    output logic [CURSOR_W-1:0]     CursorIdx,
    output logic [CURSOR_W-1:0]     SelCount,
    output logic                    ChangePulse
);
    import product_select_ctrl_pkg::*;

    logic [NUM_BTN-1:0]      btn_s;
    logic [NUM_BTN-1:0]      rise_s;
    move_state_e             state_r, state_nxt_s;
    logic [TMR_W-1:0]        timer_r, timer_nxt_s;
    logic                    dir_r, dir_nxt_s;
    logic                    move_s, move_up_s, held_s;
    logic [NUM_OF_PRDCT-1:0] mask_r, mask_nxt_s;
    logic [CURSOR_W-1:0]     cursor_r, cursor_nxt_s;
    logic [CURSOR_W-1:0]     count_r, count_nxt_s;
    logic [NUM_OF_PRDCT-1:0] cursor_oh_s;
    logic [NUM_OF_PRDCT-1:0] list_s;
    logic                    act_s;

    assign btn_s = {BTN_CLEAR, BTN_TOGGLE, BTN_PREV, BTN_NEXT};

    btn_edge_detect #(.W(NUM_BTN)) u_edge (
        .clk   (CLOCK_50),
        .rst_n (RESET_N),
        .btn   (btn_s),
        .rise  (rise_s)
    );

    // CLEAR/TOGGLE win the cycle; the move FSM then holds its state and timer
    assign act_s  = rise_s[BTN_CLEAR_IDX] | rise_s[BTN_TOGGLE_IDX];
    assign held_s = dir_r ? BTN_NEXT : BTN_PREV;

    // Move FSM, timer and selection state registers
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            state_r  <= MV_IDLE;
            timer_r  <= {TMR_W{1'b0}};
            dir_r    <= 1'b0;
            mask_r   <= {NUM_OF_PRDCT{1'b0}};
            cursor_r <= {CURSOR_W{1'b0}};
            count_r  <= {CURSOR_W{1'b0}};
        end else begin
            state_r  <= state_nxt_s;
            timer_r  <= timer_nxt_s;
            dir_r    <= dir_nxt_s;
            mask_r   <= mask_nxt_s;
            cursor_r <= cursor_nxt_s;
            count_r  <= count_nxt_s;
        end
    end

    // Move FSM next state: initial move on press, then hold delay, then auto-repeat
    always_comb begin
        state_nxt_s = state_r;
        timer_nxt_s = timer_r;
        dir_nxt_s   = dir_r;
        move_s      = 1'b0;
        move_up_s   = dir_r;
        if (LOCK) begin
            state_nxt_s = MV_IDLE;
            timer_nxt_s = {TMR_W{1'b0}};
        end else if (act_s) begin
            state_nxt_s = state_r;
        end else if (BTN_NEXT && BTN_PREV) begin
            state_nxt_s = MV_IDLE;
            timer_nxt_s = {TMR_W{1'b0}};
        end else begin
            case (state_r)
                MV_IDLE: begin
                    if (rise_s[BTN_NEXT_IDX] || rise_s[BTN_PREV_IDX]) begin
                        move_s      = 1'b1;
                        move_up_s   = rise_s[BTN_NEXT_IDX];
                        dir_nxt_s   = rise_s[BTN_NEXT_IDX];
                        timer_nxt_s = {TMR_W{1'b0}};
                        state_nxt_s = MV_HOLD;
                    end else begin
                        state_nxt_s = MV_IDLE;
                    end
                end
                MV_HOLD: begin
                    if (!held_s) begin
                        state_nxt_s = MV_IDLE;
                        timer_nxt_s = {TMR_W{1'b0}};
                    end else if (timer_r == TMR_W'(HOLD_CYCLES - 1)) begin
                        move_s      = 1'b1;
                        timer_nxt_s = {TMR_W{1'b0}};
                        state_nxt_s = MV_REPEAT;
                    end else begin
                        timer_nxt_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                MV_REPEAT: begin
                    if (!held_s) begin
                        state_nxt_s = MV_IDLE;
                        timer_nxt_s = {TMR_W{1'b0}};
                    end else if (timer_r == TMR_W'(REPEAT_CYCLES - 1)) begin
                        move_s      = 1'b1;
                        timer_nxt_s = {TMR_W{1'b0}};
                    end else begin
                        timer_nxt_s = timer_r + {{(TMR_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_nxt_s = MV_IDLE;
                    timer_nxt_s = {TMR_W{1'b0}};
                end
            endcase
        end
    end

    assign cursor_oh_s = {{(NUM_OF_PRDCT-1){1'b0}}, 1'b1} << cursor_r;

    // Selection datapath: clear, toggle with incremental count, wrapping cursor moves
    always_comb begin
        mask_nxt_s   = mask_r;
        cursor_nxt_s = cursor_r;
        count_nxt_s  = count_r;
        if (LOCK) begin
            mask_nxt_s = mask_r;
        end else if (rise_s[BTN_CLEAR_IDX]) begin
            mask_nxt_s  = {NUM_OF_PRDCT{1'b0}};
            count_nxt_s = {CURSOR_W{1'b0}};
        end else if (rise_s[BTN_TOGGLE_IDX]) begin
            mask_nxt_s = mask_r ^ cursor_oh_s;
            if (|(mask_r & cursor_oh_s)) begin
                count_nxt_s = count_r - {{(CURSOR_W-1){1'b0}}, 1'b1};
            end else begin
                count_nxt_s = count_r + {{(CURSOR_W-1){1'b0}}, 1'b1};
            end
        end else if (move_s) begin
            if (move_up_s) begin
                cursor_nxt_s = (cursor_r == CURSOR_W'(NUM_OF_PRDCT - 1)) ? {CURSOR_W{1'b0}}
                               : cursor_r + {{(CURSOR_W-1){1'b0}}, 1'b1};
            end else begin
                cursor_nxt_s = (cursor_r == {CURSOR_W{1'b0}}) ? CURSOR_W'(NUM_OF_PRDCT - 1)
                               : cursor_r - {{(CURSOR_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cursor_nxt_s = cursor_r;
        end
    end

    assign list_s = mask_r | ((CURSOR_IN_LIST != 0) ? cursor_oh_s : {NUM_OF_PRDCT{1'b0}});

    // Output registers; the pulse marks any change seen by the VGA side
    always_ff @(posedge CLOCK_50) begin
        if (!RESET_N) begin
            HighlightedProductList <= (CURSOR_IN_LIST != 0) ? {{(NUM_OF_PRDCT-1){1'b0}}, 1'b1}
                                      : {NUM_OF_PRDCT{1'b0}};
            CursorIdx              <= {CURSOR_W{1'b0}};
            SelCount               <= {CURSOR_W{1'b0}};
            ChangePulse            <= 1'b0;
        end else begin
            HighlightedProductList <= list_s;
            CursorIdx              <= cursor_r;
            SelCount               <= count_r;
            ChangePulse            <= (list_s != HighlightedProductList) ||
                                      (cursor_r != CursorIdx) || (count_r != SelCount);
        end
    end
endmodule

// File: tb/tb_product_select_ctrl.sv
// Directed and randomized bench for product_select_ctrl against a behavioural model.
module tb_product_select_ctrl;
    localparam int N    = 12;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        next = 1'b0, prev = 1'b0, tog = 1'b0, clr = 1'b0, lock = 1'b0;
    logic [11:0] list;
    logic [3:0]  cur, cnt;
    logic        pulse;

    always #5 clk = ~clk;

    product_select_ctrl #(
        .NUM_OF_PRDCT(N), .CURSOR_W(4), .HOLD_CYCLES(HOLD),
        .REPEAT_CYCLES(REP), .TMR_W(25), .CURSOR_IN_LIST(1)
    ) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .BTN_NEXT(next), .BTN_PREV(prev),
        .BTN_TOGGLE(tog), .BTN_CLEAR(clr), .LOCK(lock),
        .HighlightedProductList(list), .CursorIdx(cur), .SelCount(cnt), .ChangePulse(pulse)
    );

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    // Reference model: selection as a set, hold/repeat as elapsed-cycle arithmetic
    logic [11:0] m_mask;
    int          m_cur, m_n;
    bit          m_act, m_dir;
    logic [3:0]  m_prev;
    logic [11:0] e_list;
    int          e_cur, e_cnt;
    bit          e_pulse;
    bit          model_ok = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_move(input bit up);
        m_cur = up ? (m_cur + 1) % N : (m_cur + N - 1) % N;
    endtask

    task automatic model_step();
        logic [3:0]  b, r;
        logic [11:0] new_list;
        int          new_cnt;
        b = {clr, tog, prev, next};
        r = b & ~m_prev;
        if (!rst_n) begin
            m_mask = 12'h000; m_cur = 0; m_n = 0; m_act = 1'b0; m_dir = 1'b0;
            m_prev = 4'b0000;
            e_list = 12'h001; e_cur = 0; e_cnt = 0; e_pulse = 1'b0;
            model_ok = 1'b1;
        end else begin
            new_list = m_mask | (12'b1 << m_cur);
            new_cnt  = $countones(m_mask);
            e_pulse  = (new_list != e_list) || (m_cur != e_cur) || (new_cnt != e_cnt);
            e_list   = new_list; e_cur = m_cur; e_cnt = new_cnt;
            m_prev   = b;
            if (lock) m_act = 1'b0;
            else if (r[3]) m_mask = 12'h000;
            else if (r[2]) m_mask = m_mask ^ (12'b1 << m_cur);
            else if (next && prev) m_act = 1'b0;
            else if (!m_act) begin
                if (r[0] || r[1]) begin
                    m_act = 1'b1; m_dir = r[0]; m_n = 0; model_move(m_dir);
                end
            end else if (!(m_dir ? next : prev)) m_act = 1'b0;
            else begin
                m_n++;
                if (m_n == HOLD || (m_n > HOLD && (m_n - HOLD) % REP == 0)) model_move(m_dir);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        if (pulse === 1'b1) pulse_cnt++;
        if (model_ok) begin
            chk("list",   32'(list),  32'(e_list));
            chk("cursor", 32'(cur),   32'(e_cur));
            chk("count",  32'(cnt),   32'(e_cnt));
            chk("pulse",  32'(pulse), 32'(e_pulse));
        end
    endtask

    task automatic press(input int idx);
        case (idx)
            0: next = 1'b1;
            1: prev = 1'b1;
            2: tog  = 1'b1;
            default: clr = 1'b1;
        endcase
        cycle();
        next = 1'b0; prev = 1'b0; tog = 1'b0; clr = 1'b0;
        cycle();
        cycle();
    endtask

    initial begin
        int pmask;
        // 1: reset values, then three NEXT presses
        repeat (3) cycle();
        rst_n = 1'b1;
        cycle();
        chk("rst_list", 32'(list), 32'h001);
        chk("rst_cur", 32'(cur), 32'd0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_pulse", 32'(pulse), 32'd0);
        pulse_cnt = 0;
        repeat (3) press(0);
        chk("s1_cur", 32'(cur), 32'd3);
        chk("s1_list", 32'(list), 32'h008);
        chk("s1_pulses", 32'(pulse_cnt), 32'd3);

        // 2: wrap in both directions
        repeat (4) press(1);
        chk("s2_cur11", 32'(cur), 32'd11);
        press(0);
        chk("s2_wrap0", 32'(cur), 32'd0);
        press(1);
        chk("s2_wrap11", 32'(cur), 32'd11);
        chk("s2_list", 32'(list), 32'h800);

        // 3: toggles at 0, 5, 11 then clear
        press(0); press(2);
        repeat (5) press(0);
        press(2);
        repeat (6) press(1);
        press(2);
        chk("s3_list", 32'(list), 32'h821);
        chk("s3_cnt", 32'(cnt), 32'd3);
        press(3);
        chk("s3_clr_list", 32'(list), 32'h800);
        chk("s3_clr_cnt", 32'(cnt), 32'd0);
        chk("s3_clr_cur", 32'(cur), 32'd11);

        // 4: hold NEXT for 20 cycles from cursor 0
        press(0);
        pmask = 0;
        next = 1'b1;
        for (int i = 0; i < 26; i++) begin
            if (i == 20) next = 1'b0;
            cycle();
            if (pulse === 1'b1) pmask = pmask | (1 << i);
        end
        chk("s4_pulse_times", 32'(pmask), 32'h00022202);
        chk("s4_cur", 32'(cur), 32'd4);

        // 5: simultaneous NEXT+PREV, then CLEAR+TOGGLE
        pulse_cnt = 0;
        next = 1'b1; prev = 1'b1;
        cycle();
        next = 1'b0; prev = 1'b0;
        repeat (3) cycle();
        chk("s5_np_pulses", 32'(pulse_cnt), 32'd0);
        chk("s5_np_cur", 32'(cur), 32'd4);
        press(2);
        chk("s5_tog_cnt", 32'(cnt), 32'd1);
        clr = 1'b1; tog = 1'b1;
        cycle();
        clr = 1'b0; tog = 1'b0;
        repeat (2) cycle();
        chk("s5_ct_cnt", 32'(cnt), 32'd0);
        chk("s5_ct_list", 32'(list), 32'h010);

        // 6: LOCK freezes, held button across unlock is ignored, reset mid-repeat
        press(2);
        lock = 1'b1;
        pulse_cnt = 0;
        press(0); press(2); press(3); press(1);
        chk("s6_lock_pulses", 32'(pulse_cnt), 32'd0);
        chk("s6_lock_list", 32'(list), 32'h010);
        chk("s6_lock_cnt", 32'(cnt), 32'd1);
        next = 1'b1;
        cycle();
        lock = 1'b0;
        repeat (3) cycle();
        chk("s6_unlock_cur", 32'(cur), 32'd4);
        next = 1'b0;
        cycle();
        next = 1'b1;
        repeat (12) cycle();
        rst_n = 1'b0;
        cycle();
        chk("s6_rst_list", 32'(list), 32'h001);
        chk("s6_rst_cur", 32'(cur), 32'd0);
        chk("s6_rst_cnt", 32'(cnt), 32'd0);
        chk("s6_rst_pulse", 32'(pulse), 32'd0);
        next = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();

        // Randomized phase with sticky buttons so holds and repeats occur
        for (int i = 0; i < 800; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            lock  = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 5) == 0) next = ~next;
            if ($urandom_range(0, 7) == 0) prev = ~prev;
            if ($urandom_range(0, 3) == 0) tog  = ~tog;
            if ($urandom_range(0, 9) == 0) clr  = ~clr;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
